// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and flush controller for the IF -> DOF -> EX -> WB RISC pipeline.
// It keeps a small shadow copy of the write information for the instructions
// in EX and WB. It stalls PC/IF/DOF while the DOF instruction reads a register
// that one of those instructions still has to write. It flushes IF/DOF when a
// control transfer resolved in EX is taken. On a stall, a flush, or an empty
// DOF slot, it loads a NOP bubble into the EX pipeline register.
//
// Parameters:
//   CNT_W      width of the saturating stall / flush performance counters
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      synchronous, active-high
//   RW_D       DOF-stage register-write enable
//   DA_D       DOF-stage destination register
//   AA_D       DOF-stage A-operand register
//   BA_D       DOF-stage B-operand register
//   MA_D       DOF-stage A-mux select (1 = PC, register file not read)
//   MB_D       DOF-stage B-mux select (1 = constant, register file not read)
//   BS_E       EX-stage branch select (00 none, 01 cond, 10 JMR, 11 JMP/JML)
//   PS_E       EX-stage branch polarity (0 = BZ, 1 = BNZ)
//   Z_E        EX-stage ALU zero flag
//   clr_cnt    synchronous clear of both performance counters
//   stall      hold PC, IF/DOF register and DOF/EX sources (combinational)
//   flush      taken transfer in EX: load target, clear IF/DOF (combinational)
//   ex_bubble  load a NOP into the EX pipeline register (combinational)
//   stall_cnt  number of cycles with stall = 1 (saturating)
//   flush_cnt  number of cycles with flush = 1 (saturating)

module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RW_D,
  input  logic [4:0]       DA_D,
  input  logic [4:0]       AA_D,
  input  logic [4:0]       BA_D,
  input  logic             MA_D,
  input  logic             MB_D,
  input  logic [1:0]       BS_E,
  input  logic             PS_E,
  input  logic             Z_E,
  input  logic             clr_cnt,
  output logic             stall,
  output logic             flush,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       dof_v;
  logic       ex_v;
  logic       ex_rw;
  logic [4:0] ex_da;
  logic       wb_v;
  logic       wb_rw;
  logic [4:0] wb_da;

  logic match_a;
  logic match_b;
  logic hz;
  logic taken;

  // R0 is hardwired to zero, so it never carries a dependency. The register
  // file has no write-through path, so a producer still sitting in WB
  // conflicts just like one in EX.
  always_comb begin
    match_a = (AA_D != 5'd0) &&
              ((ex_v && ex_rw && (ex_da == AA_D)) ||
               (wb_v && wb_rw && (wb_da == AA_D)));
    match_b = (BA_D != 5'd0) &&
              ((ex_v && ex_rw && (ex_da == BA_D)) ||
               (wb_v && wb_rw && (wb_da == BA_D)));
    hz      = dof_v && ((!MA_D && match_a) || (!MB_D && match_b));
  end

  // Conditional branches are taken when Z differs from the polarity bit:
  // BZ (PS=0) on Z=1, BNZ (PS=1) on Z=0. JMR/JMP/JML always transfer.
  always_comb begin
    taken = 1'b0;
    if (ex_v) begin
      case (BS_E)
        2'b00:   taken = 1'b0;
        2'b01:   taken = Z_E ^ PS_E;
        default: taken = 1'b1;
      endcase
    end
  end

  // The stalled DOF instruction is younger than the transfer and is about to
  // be killed, so a flush suppresses the stall.
  assign flush     = taken;
  assign stall     = hz && !taken;
  assign ex_bubble = stall || taken || !dof_v;

  // The shadow pipeline follows the real pipeline registers. A flush clears
  // dof_v to kill the IF instruction. The DOF instruction is killed by the
  // bubble loaded into EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      dof_v <= 1'b0;
      ex_v  <= 1'b0;
      ex_rw <= 1'b0;
      ex_da <= 5'd0;
      wb_v  <= 1'b0;
      wb_rw <= 1'b0;
      wb_da <= 5'd0;
    end else begin
      wb_v  <= ex_v;
      wb_rw <= ex_rw;
      wb_da <= ex_da;
      if (ex_bubble) begin
        ex_v  <= 1'b0;
        ex_rw <= 1'b0;
        ex_da <= 5'd0;
      end else begin
        ex_v  <= 1'b1;
        ex_rw <= RW_D;
        ex_da <= DA_D;
      end
      if (!stall) begin
        dof_v <= !taken;
      end
    end
  end

  // Saturating performance counters. A clear wins over an increment in the
  // same cycle.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule
